// File: rtl/uart_word_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_word_tx_if
//  Brief    : Word handshake and serial-line bundle for uart_word_tx.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_word_tx_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        tx;
  logic        busy;
  logic        word_done;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready,
    input  tx,
    input  busy,
    input  word_done
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready,
    output tx,
    output busy,
    output word_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_word_tx
//  Brief    : Sends each accepted 32-bit word as four 8N1 frames, LSB byte first.
//  Revision : 1.0  initial release
// ============================================================================
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  wire logic     clk,
  input  wire logic     rst,
  uart_word_tx_if.slave s_word
);

  localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_bit;
  logic [1:0]           r_byte;
  logic [31:0]          r_word;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]           w_bit_nxt;
  logic [1:0]           w_byte_nxt;
  logic [31:0]          w_word_nxt;
  logic                 w_tx_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_accept;
  logic                 w_bit_end;

  assign s_word.word_ready = (r_state == S_IDLE) & ~rst;
  assign s_word.tx         = r_tx;
  assign s_word.busy       = r_busy;
  assign s_word.word_done  = r_done;

  assign w_accept  = s_word.word_valid & s_word.word_ready;
  assign w_bit_end = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_word  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_word  <= w_word_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_word_nxt  = r_word;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_START;
          w_word_nxt  = s_word.word_data;
          w_byte_nxt  = 2'd0;
          w_bit_nxt   = 3'd0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          w_bit_nxt = 3'd0;
          if (r_byte != 2'd3) begin
            w_byte_nxt  = r_byte + 2'd1;
            w_state_nxt = S_START;
          end else begin
            w_byte_nxt  = 2'd0;
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Line level is derived from the next state so tx is a clean flop output.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_word_nxt[{w_byte_nxt, w_bit_nxt}];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_word_tx
//  Brief    : Self-checking bench for uart_word_tx against a timing-formula model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_word_tx;

  localparam int C    = 4;
  localparam int LAST = 40 * C + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  uart_word_tx_if bus ();

  uart_word_tx #(.CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_word (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line level n cycles after the acceptance edge.
  function automatic logic exp_tx(input logic [31:0] w, input int n);
    int off, b, pos;
    logic [31:0] ww;
    if (n < 1 || n > 40 * C) return 1'b1;
    off = n - 1;
    b   = off / (10 * C);
    pos = (off % (10 * C)) / C;
    ww  = w;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return ww[b * 8 + pos - 1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a word and returns in cycle 1 after its acceptance edge.
  task automatic accept_word(input logic [31:0] w, input bit keep_valid);
    int budget = 0;
    bus.word_valid = 1'b1;
    bus.word_data  = w;
    while (!bus.word_ready && budget < LAST + 10) begin
      tick();
      budget++;
    end
    checks++;
    if (bus.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout word_ready=%b required=1", bus.word_ready);
    end
    tick();
    if (!keep_valid) bus.word_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.word_ready !== 1'b0 || bus.word_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d tx=%b busy=%b ready=%b done=%b required 1 0 0 0",
                 i, bus.tx, bus.busy, bus.word_ready, bus.word_done);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.word_ready !== 1'b1 || bus.tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready=%b tx=%b required 1 1", bus.word_ready, bus.tx);
    end
    tick();
    checks++;
    if (bus.word_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle ready=%b busy=%b required 1 0", bus.word_ready, bus.busy);
    end
  endtask

  task automatic test_single(input logic [31:0] w);
    logic e_tx;
    accept_word(w, 1'b0);
    for (int n = 1; n <= LAST; n++) begin
      e_tx = exp_tx(w, n);
      checks++;
      if (bus.tx !== e_tx || bus.busy !== (n <= 40 * C) ||
          bus.word_done !== (n == LAST) || bus.word_ready !== (n == LAST)) begin
        errors++;
        $display("FAIL single w=%h n=%0d tx=%b busy=%b done=%b ready=%b required tx=%b busy=%b done=%b ready=%b",
                 w, n, bus.tx, bus.busy, bus.word_done, bus.word_ready,
                 e_tx, (n <= 40 * C), (n == LAST), (n == LAST));
      end
      tick();
    end
    checks++;
    if (bus.word_done !== 1'b0 || bus.tx !== 1'b1) begin
      errors++;
      $display("FAIL single_after w=%h done=%b tx=%b required 0 1", w, bus.word_done, bus.tx);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      test_single($urandom);
    end
  endtask

  task automatic test_data_stability();
    logic [31:0] w;
    logic        e_tx;
    w = 32'hA5A5_A5A5;
    accept_word(w, 1'b0);
    bus.word_data = 32'hFFFF_FFFF;
    for (int n = 1; n <= LAST; n++) begin
      e_tx = exp_tx(w, n);
      checks++;
      if (bus.tx !== e_tx || bus.word_done !== (n == LAST)) begin
        errors++;
        $display("FAIL stability n=%0d tx=%b done=%b required tx=%b done=%b",
                 n, bus.tx, bus.word_done, e_tx, (n == LAST));
      end
      tick();
    end
  endtask

  task automatic test_valid_busy();
    logic [31:0] w;
    logic        e_tx;
    w = $urandom;
    accept_word(w, 1'b0);
    for (int n = 1; n <= LAST; n++) begin
      if (n == 50) begin
        bus.word_valid = 1'b1;
        bus.word_data  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.word_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready n=%0d ready=%b required=0", n, bus.word_ready);
        end
      end
      if (n == 51) bus.word_valid = 1'b0;
      e_tx = exp_tx(w, n);
      checks++;
      if (bus.tx !== e_tx || bus.busy !== (n <= 40 * C)) begin
        errors++;
        $display("FAIL valid_busy n=%0d tx=%b busy=%b required tx=%b busy=%b",
                 n, bus.tx, bus.busy, e_tx, (n <= 40 * C));
      end
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      errors++;
      $display("FAIL valid_busy_queued busy=%b tx=%b required 0 1", bus.busy, bus.tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [2];
    logic        e_tx;
    int          dones = 0;
    words[0] = 32'h0000_0001;
    words[1] = 32'h8000_0000;
    accept_word(words[0], 1'b1);
    for (int k = 0; k < 2; k++) begin
      for (int n = 1; n <= LAST; n++) begin
        e_tx = exp_tx(words[k], n);
        if (bus.word_done === 1'b1) dones++;
        checks++;
        if (bus.tx !== e_tx || bus.busy !== (n <= 40 * C) || bus.word_ready !== (n == LAST)) begin
          errors++;
          $display("FAIL b2b word=%0d n=%0d tx=%b busy=%b ready=%b required tx=%b busy=%b ready=%b",
                   k, n, bus.tx, bus.busy, bus.word_ready, e_tx, (n <= 40 * C), (n == LAST));
        end
        if (n == LAST) begin
          if (k == 0) bus.word_data  = words[1];
          else        bus.word_valid = 1'b0;
        end
        tick();
      end
    end
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d required=2", dones);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_third busy=%b required=0", bus.busy);
    end
  endtask

  task automatic test_reset_midword();
    logic [31:0] w;
    logic        e_tx;
    int          cut;
    w   = $urandom;
    cut = 1 + 10 * C + 4 * C;
    accept_word(w, 1'b0);
    for (int n = 1; n <= cut; n++) begin
      e_tx = exp_tx(w, n);
      checks++;
      if (bus.tx !== e_tx) begin
        errors++;
        $display("FAIL pre_abort n=%0d tx=%b required=%b", n, bus.tx, e_tx);
      end
      if (n < cut) tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.word_done !== 1'b0 || bus.word_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort tx=%b busy=%b done=%b ready=%b required 1 0 0 0",
               bus.tx, bus.busy, bus.word_done, bus.word_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_release ready=%b required=1", bus.word_ready);
    end
    test_single(32'h0000_00FF);
  endtask

  initial begin
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    test_reset();
    test_single(32'h1234_5678);
    test_random();
    test_data_stability();
    test_valid_busy();
    test_back_to_back();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
